// File: rtl/relu_maxpool_2x2.sv
// relu_maxpool_2x2: bias + ReLU + requantise + saturate, then 2x2 stride-2 max-pool over a raster pixel stream.
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   in_valid, in_sof  : pixel strobe and start-of-frame (sof only counts with in_valid)
//   in_sum, bias      : signed W2-bit sum from the channel adder and per-map bias
//   out_valid, out_act: one pooled OW-bit activation per 2x2 window
//   frame_done        : pulses with the last out_valid of a frame
//   sat_flag          : sticky saturation flag, present only when SAT_FLAG_EN is defined
module relu_maxpool_2x2 #(
    parameter int W2    = 24,
    parameter int OW    = 8,
    parameter int SHIFT = 8,
    parameter int IMG_W = 24,
    parameter int IMG_H = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic signed [W2-1:0] in_sum,
    input  logic signed [W2-1:0] bias,
    output logic                 out_valid,
    output logic [OW-1:0]        out_act,
    output logic                 frame_done
`ifdef SAT_FLAG_EN
    ,
    output logic                 sat_flag
`endif
);
    localparam int LW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
    localparam int CW = LW + 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic signed [W2:0] sum_d;
    logic [W2:0]        relu_d, shr_d;
    logic               sat_d;
    logic [OW-1:0]      act_d;

    // One extra bit keeps the bias add exact; after ReLU the value is non-negative,
    // so any set bit above OW after the shift means saturation.
    assign sum_d  = {in_sum[W2-1], in_sum} + {bias[W2-1], bias};
    assign relu_d = sum_d[W2] ? '0 : sum_d;
    assign shr_d  = relu_d >> SHIFT;
    assign sat_d  = |shr_d[W2:OW];
    assign act_d  = sat_d ? '1 : shr_d[OW-1:0];

    logic          s1_valid_q, s1_sof_q;
    logic [OW-1:0] s1_act_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_act_q   <= '0;
        end else begin
            s1_valid_q <= in_valid;
            s1_sof_q   <= in_valid & in_sof;
            s1_act_q   <= act_d;
        end
    end

    logic [CW-1:0] col_q, col_d, col_pos;
    logic [RW-1:0] row_q, row_d, row_pos;
    logic [OW-1:0] hold_q, hold_d, out_act_q, out_act_d, pair_max, lbuf_rd, win_max;
    logic          out_valid_q, out_valid_d, frame_done_q, frame_done_d;
    logic          col_last, row_last, emit, lbuf_we;
    logic [LW-1:0] lidx;
    logic [OW-1:0] lbuf [IMG_W/2];

    // A start-of-frame pixel is placed at (0,0) regardless of the counters.
    assign col_pos  = s1_sof_q ? '0 : col_q;
    assign row_pos  = s1_sof_q ? '0 : row_q;
    assign col_last = col_pos == COL_LAST;
    assign row_last = row_pos == ROW_LAST;
    assign lidx     = col_pos[LW:1];
    assign lbuf_rd  = lbuf[lidx];
    assign pair_max = (s1_act_q > hold_q) ? s1_act_q : hold_q;
    assign win_max  = (lbuf_rd > pair_max) ? lbuf_rd : pair_max;
    assign emit     = s1_valid_q & col_pos[0] & row_pos[0];
    assign lbuf_we  = s1_valid_q & col_pos[0] & ~row_pos[0];

    always_comb begin
        col_d        = !s1_valid_q ? col_q : col_last ? '0 : col_pos + CW'(1);
        row_d        = !s1_valid_q ? row_q : !col_last ? row_pos : row_last ? '0 : row_pos + RW'(1);
        hold_d       = (s1_valid_q & ~col_pos[0]) ? s1_act_q : hold_q;
        out_valid_d  = emit;
        out_act_d    = emit ? win_max : out_act_q;
        frame_done_d = s1_valid_q & row_last & col_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            out_valid_q  <= 1'b0;
            out_act_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            out_valid_q  <= out_valid_d;
            out_act_q    <= out_act_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (lbuf_we) lbuf[lidx] <= pair_max;
    end

    assign out_valid  = out_valid_q;
    assign out_act    = out_act_q;
    assign frame_done = frame_done_q;

`ifdef SAT_FLAG_EN
    logic s1_sat_q, sat_flag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sat_q   <= 1'b0;
            sat_flag_q <= 1'b0;
        end else begin
            s1_sat_q <= in_valid & sat_d;
            if (s1_valid_q) sat_flag_q <= s1_sat_q | (sat_flag_q & ~s1_sof_q);
        end
    end

    assign sat_flag = sat_flag_q;
`endif
endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// tb_relu_maxpool_2x2: scoreboard bench for the ReLU/requantise/2x2 max-pool stage on a 4x4 frame.
module tb_relu_maxpool_2x2;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_sof;
    logic [23:0] in_sum, bias;
    logic        out_valid, frame_done;
    logic [7:0]  out_act;
`ifdef SAT_FLAG_EN
    logic        sat_flag;
`endif

    relu_maxpool_2x2 #(.W2(24), .OW(8), .SHIFT(8), .IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_sum(in_sum), .bias(bias), .out_valid(out_valid), .out_act(out_act),
        .frame_done(frame_done)
`ifdef SAT_FLAG_EN
        , .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] act; bit fd; int due; } exp_t;
    typedef struct { logic [23:0] b; logic [23:0] s; logic [7:0] e; } vec_t;

    exp_t        sb[$];
    vec_t        vt[12];
    logic [23:0] fv[16];
    logic [7:0]  fe[4];
    int          cyc = 0, nchk = 0, npass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input int act, input int req);
        nchk++;
        if (ok) npass++;
        else $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                chk(1'b0, "missing_out", 0, int'(sb[0].act));
                void'(sb.pop_front());
            end
            if (out_valid) begin
                if (sb.size() == 0) chk(1'b0, "spurious_out", int'(out_act), -1);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk(e.due == cyc, "out_latency", cyc, e.due);
                    chk(out_act == e.act && frame_done == e.fd, "out_act_fd",
                        int'({frame_done, out_act}), int'({e.fd, e.act}));
                end
            end else if (frame_done) chk(1'b0, "lone_frame_done", 1, 0);
        end
    end

    task automatic px(input logic [23:0] s, input bit sof, input bit v);
        in_valid = v;
        in_sof   = sof;
        in_sum   = s;
        @(negedge clk);
    endtask

    // Drives pixels 0..n-1 of fv; expectations fe[] are queued on each window's bottom-right pixel.
    task automatic run_frame(input int n, input bit sof, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if ((k & 1) == 1 && ((k >> 2) & 1) == 1)
                sb.push_back('{fe[(k >> 3) * 2 + ((k >> 1) & 1)], k == 15, cyc + 2});
            px(fv[k], sof && k == 0, 1'b1);
            if (gaps) px(24'hABCDEF, 1'b1, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(24'h0, 1'b0, 1'b0);
    endtask

    task automatic basic;
        for (int k = 0; k < 16; k++) fv[k] = 24'(k * 256);
        fe[0] = 8'd5; fe[1] = 8'd7; fe[2] = 8'd13; fe[3] = 8'd15;
    endtask

    initial begin
        vt[0]  = '{24'd0,       24'd0,       8'd0};
        vt[1]  = '{24'd356,     -24'sd100,   8'd1};
        vt[2]  = '{24'd356,     -24'sd400,   8'd0};
        vt[3]  = '{24'd0,       24'h7FFFFF,  8'd255};
        vt[4]  = '{24'd0,       24'd65280,   8'd255};
        vt[5]  = '{24'd0,       24'd65536,   8'd255};
        vt[6]  = '{24'd0,       24'd511,     8'd1};
        vt[7]  = '{-24'sd512,   24'd1000,    8'd1};
        vt[8]  = '{24'h7FFFFF,  24'h7FFFFF,  8'd255};
        vt[9]  = '{24'h800000,  24'h800000,  8'd0};
        vt[10] = '{24'd100,     24'd200,     8'd1};
        vt[11] = '{24'd0,       24'hFFFFFF,  8'd0};

        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_sum = '0; bias = '0;
        repeat (3) @(negedge clk);
        chk(out_valid == 1'b0, "reset_out_valid", int'(out_valid), 0);
        chk(out_act == 8'd0, "reset_out_act", int'(out_act), 0);
        chk(frame_done == 1'b0, "reset_frame_done", int'(frame_done), 0);
        rst_n = 1'b1;
        idle(2);

        basic();
        run_frame(16, 1'b1, 1'b0);
        idle(4);

        for (int i = 0; i < 12; i++) begin
            bias = vt[i].b;
            for (int k = 0; k < 16; k++) fv[k] = vt[i].s;
            for (int w = 0; w < 4; w++) fe[w] = vt[i].e;
            run_frame(16, 1'b1, 1'b0);
        end
        idle(4);
        bias = '0;

        basic();
        run_frame(16, 1'b1, 1'b1);
        idle(4);

        run_frame(7, 1'b1, 1'b0);
        idle(1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(16, 1'b0, 1'b0);
        idle(4);

        run_frame(9, 1'b1, 1'b0);
        run_frame(16, 1'b1, 1'b0);
        idle(4);

`ifdef SAT_FLAG_EN
        for (int k = 0; k < 16; k++) fv[k] = 24'h7FFFFF;
        for (int w = 0; w < 4; w++) fe[w] = 8'd255;
        run_frame(16, 1'b1, 1'b0);
        idle(3);
        chk(sat_flag == 1'b1, "sat_flag_set", int'(sat_flag), 1);
        basic();
        run_frame(16, 1'b1, 1'b0);
        idle(3);
        chk(sat_flag == 1'b0, "sat_flag_clear", int'(sat_flag), 0);
`endif

        idle(4);
        chk(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/relu_maxpool_2x2.md
Name: relu_maxpool_2x2

Overview:
- Downstream consumer of the 8-input channel adder: takes its signed W2-bit sums as a raster-order pixel stream, one per valid cycle.
- Each sum gets bias add, ReLU, right shift and unsigned saturation to OW bits.
- 2x2 stride-2 max-pooling then runs over the frame using a half-width line buffer.
- Emits one pooled OW-bit activation per 2x2 window to the next conv/dense layer.

Parameters:
- W2, 24, width of signed input sum and of bias.
- OW, 8, width of unsigned output activation.
- SHIFT, 8, arithmetic right shift applied after ReLU (requantisation).
- IMG_W, 24, input frame width in pixels; must be even, >=2.
- IMG_H, 24, input frame height in pixels; must be even, >=2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_sum carries a pixel this cycle.
- in_sof  in  1  start of frame; qualified by in_valid.
- in_sum  in  W2  signed sum from the channel adder.
- bias  in  W2  signed per-feature-map bias; held stable for the whole frame.
- out_valid  out  1  one-cycle pulse; out_act is valid.
- out_act  out  OW  unsigned pooled activation.
- frame_done  out  1  pulses together with the last out_valid of a frame.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_act=0, frame_done=0, row/col counters=0, hold regs=0, stage-1 valid=0. Line buffer contents need not be cleared; they are always written before being read.
- Stage 1, registered, latency 1:
  - s = sign-extend(in_sum) + sign-extend(bias), computed at W2+1 bits with no overflow.
  - r = (s<0) ? 0 : s.
  - q = r >>> SHIFT.
  - a = (q > 2^OW-1) ? 2^OW-1 : q[OW-1:0].
  - Stage-1 valid = in_valid.
- Position: col counts 0..IMG_W-1 and row counts 0..IMG_H-1, advanced only by a stage-1 valid pixel.
  - col wraps to 0 and increments row.
  - At row=IMG_H-1, col=IMG_W-1 both wrap to 0.
- in_sof with in_valid forces that pixel to position (0,0), discarding any partial frame state. An in_sof without in_valid is ignored.
- Pooling, per stage-1 valid pixel a at (row, col):
  - Even col: hold <= a.
  - Even row, odd col: lbuf[col>>1] <= max(hold, a).
  - Odd row, odd col: out_act <= max(hold, a, lbuf[col>>1]) and out_valid <= 1.
  - frame_done <= 1 when row=IMG_H-1 and col=IMG_W-1.
- Latency: out_valid is asserted 2 clk edges after the in_valid cycle carrying the bottom-right pixel of its window.
- Throughput: one pixel per cycle. There is no backpressure; the downstream stage must accept every out_valid.
- Gaps (in_valid=0): no counter or buffer change. out_valid and frame_done are 0 unless set by the previous stage-1 pixel.
- out_act holds its last value when out_valid=0.
- Line buffer: IMG_W/2 entries of OW bits, single write and single read per cycle, same index.
- Reset mid-frame: all state is cleared. The next pixel is treated as (0,0) whether or not in_sof is asserted.

Optional Feature:
- Macro SAT_FLAG_EN.
- When defined:
  - Adds output port sat_flag (1 bit, reset 0), a sticky flag set in the cycle after any stage-1 pixel saturates (q > 2^OW-1).
  - Cleared by a valid in_sof pixel; if that same pixel saturates, the flag is set instead.
  - Read by the layer controller for requantisation tuning.
- When not defined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Basic pooling (IMG_W=IMG_H=4, bias=0, SHIFT=8): in_sum=k*256 for k=0..15, raster order, continuous, in_sof on k=0 -> out_act 5,7,13,15 on 4 out_valid pulses. frame_done coincides with the 15 output, 2 cycles after k=15 is presented.
- ReLU/bias: bias=356, SHIFT=8, in_sum=-100 -> a=1; in_sum=-400 -> a=0. A window of all -400 -> out_act=0.
- Saturation: in_sum=24'h7FFFFF, bias=0, SHIFT=8 -> a=255. With SAT_FLAG_EN, sat_flag=1 from the next cycle until the next in_sof frame with no saturation.
- Gapped input: the basic-pooling stream with in_valid deasserted every other cycle -> identical outputs 5,7,13,15. Each output is 2 cycles after its window's last valid pixel; there are no spurious out_valid pulses.
- Reset mid-frame: rst_n low for 1 cycle after pixel k=6, then a full frame without in_sof -> outputs match the basic-pooling result; no output derived from pre-reset pixels.
- Resync: in_sof asserted at pixel k=9 of a frame, followed by a full 16-pixel frame -> outputs 5,7,13,15. No output fires for the truncated frame after the resync point.
